// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm trigger block.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned SEC_PER_MIN = 60;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: the pulse appears one clk after the level is sampled high.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
    end
  end

endmodule

// File: rtl/alarm_trigger.sv
// Compares the running BCD time against the alarm setting and drives ring/snooze/buzzer
// behaviour, with button-edge control and automatic timeouts.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [3:0] t_first,
  input  logic [3:0] t_second,
  input  logic [3:0] t_third,
  input  logic [3:0] t_fourth,
  input  logic [3:0] a_first,
  input  logic [3:0] a_second,
  input  logic [3:0] a_third,
  input  logic [3:0] a_fourth,
  input  logic       alarm_en,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic       ringing,
  output logic       snoozed,
  output logic       buzzer,
  output logic [1:0] snooze_count
);

  localparam int unsigned SNZ_SECONDS = SNOOZE_MINUTES * SEC_PER_MIN;
  localparam int unsigned RW = $clog2(RING_SECONDS + 1);
  localparam int unsigned SW = $clog2(SNZ_SECONDS + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNZ_SECONDS - 1);
  localparam logic [1:0]    MAX_SNZ   = 2'(MAX_SNOOZE);

  bcd_digit_t now_time   [4];
  bcd_digit_t alarm_time [4];

  state_t        state, state_n;
  logic [RW-1:0] ring_cnt, ring_n;
  logic [SW-1:0] snz_cnt, snz_n;
  logic [1:0]    count_n;
  logic          buzz_n;
  logic          match_c, match_q, rise;
  logic          snooze_edge, stop_edge;
  logic          to_idle;

  assign now_time   = '{t_first, t_second, t_third, t_fourth};
  assign alarm_time = '{a_first, a_second, a_third, a_fourth};

  always_comb begin
    match_c = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (now_time[i] != alarm_time[i]) match_c = 1'b0;
    end
  end

  assign rise = match_c & ~match_q;

  edge_detect u_snooze_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_snooze),
    .rise  (snooze_edge)
  );

  edge_detect u_stop_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_stop),
    .rise  (stop_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ring_cnt     <= '0;
      snz_cnt      <= '0;
      snooze_count <= '0;
      buzzer       <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      state        <= state_n;
      ring_cnt     <= ring_n;
      snz_cnt      <= snz_n;
      snooze_count <= count_n;
      buzzer       <= buzz_n;
      match_q      <= match_c;
    end
  end

  always_comb begin
    state_n = state;
    ring_n  = ring_cnt;
    snz_n   = snz_cnt;
    count_n = snooze_count;
    buzz_n  = buzzer;
    to_idle = 1'b0;

    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = RINGING;
          ring_n  = '0;
          buzz_n  = 1'b1;
        end
      end
      RINGING: begin
        if (stop_edge) begin
          to_idle = 1'b1;
        end else if (snooze_edge) begin
          if (snooze_count < MAX_SNZ) begin
            state_n = SNOOZE;
            count_n = snooze_count + 2'd1;
            snz_n   = '0;
            buzz_n  = 1'b0;
          end else begin
            to_idle = 1'b1;
          end
        end else if (sec_tick) begin
          if (ring_cnt == RING_LAST) begin
            to_idle = 1'b1;
          end else begin
            ring_n = ring_cnt + 1'b1;
            buzz_n = ~buzzer;
          end
        end
      end
      SNOOZE: begin
        if (stop_edge) begin
          to_idle = 1'b1;
        end else if (sec_tick) begin
          if (snz_cnt == SNZ_LAST) begin
            state_n = RINGING;
            ring_n  = '0;
            buzz_n  = 1'b1;
          end else begin
            snz_n = snz_cnt + 1'b1;
          end
        end
      end
      default: to_idle = 1'b1;
    endcase

    // Disarming overrides everything, including an IDLE->RINGING trigger in the same cycle.
    if (to_idle || !alarm_en) begin
      state_n = IDLE;
      ring_n  = '0;
      snz_n   = '0;
      count_n = '0;
      buzz_n  = 1'b0;
    end
  end

  assign ringing = (state == RINGING);
  assign snoozed = (state == SNOOZE);

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with a queue of expected output snapshots.
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic [3:0] t_first = '0, t_second = '0, t_third = '0, t_fourth = '0;
  logic [3:0] a_first = '0, a_second = '0, a_third = '0, a_fourth = '0;
  logic       alarm_en = 1'b0;
  logic       btn_snooze = 1'b0;
  logic       btn_stop = 1'b0;
  logic       ringing, snoozed, buzzer;
  logic [1:0] snooze_count;

  typedef struct {
    string      tag;
    logic [4:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alarm_trigger #(
    .RING_SECONDS   (4),
    .SNOOZE_MINUTES (1),
    .MAX_SNOOZE     (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sec_tick     (sec_tick),
    .t_first      (t_first),
    .t_second     (t_second),
    .t_third      (t_third),
    .t_fourth     (t_fourth),
    .a_first      (a_first),
    .a_second     (a_second),
    .a_third      (a_third),
    .a_fourth     (a_fourth),
    .alarm_en     (alarm_en),
    .btn_snooze   (btn_snooze),
    .btn_stop     (btn_stop),
    .ringing      (ringing),
    .snoozed      (snoozed),
    .buzzer       (buzzer),
    .snooze_count (snooze_count)
  );

  // Expected snapshot packing: {ringing, snoozed, buzzer, snooze_count}
  task automatic expect_out(input string tag, input bit r, input bit s, input bit b,
                            input logic [1:0] c);
    exp_t e;
    e.tag   = tag;
    e.value = {r, s, b, c};
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [4:0] obs;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = {ringing, snoozed, buzzer, snooze_count};
      checks++;
      assert (obs === e.value)
      else begin
        errors++;
        $error("FAIL %s: observed r/s/b/cnt=%b expected=%b", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic set_time(input logic [3:0] ht, input logic [3:0] ho,
                          input logic [3:0] mt, input logic [3:0] mo);
    t_fourth = ht; t_third = ho; t_second = mt; t_first = mo;
  endtask

  task automatic set_alarm(input logic [3:0] ht, input logic [3:0] ho,
                           input logic [3:0] mt, input logic [3:0] mo);
    a_fourth = ht; a_third = ho; a_second = mt; a_first = mo;
  endtask

  task automatic press(input bit snz, input bit stp);
    btn_snooze = snz;
    btn_stop   = stp;
    step();
    btn_snooze = 1'b0;
    btn_stop   = 1'b0;
    step();
  endtask

  // Leave 07:30 and come back to it so the comparator produces a fresh rise.
  task automatic retrigger();
    set_time(0, 7, 3, 1);
    step();
    set_time(0, 7, 3, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_alarm(0, 7, 3, 0);
    set_time(0, 7, 2, 9);
    alarm_en = 1'b1;
    step();
    step();
    expect_out("reset_state", 0, 0, 0, 2'd0);
    check_out();
    rst_n = 1'b1;
    step();
    expect_out("idle_before_match", 0, 0, 0, 2'd0);
    check_out();

    set_time(0, 7, 3, 0);
    expect_out("trigger_latency", 1, 0, 1, 2'd0);
    step();
    check_out();

    expect_out("tick1_toggle", 1, 0, 0, 2'd0);
    tick(); check_out();
    expect_out("tick2_toggle", 1, 0, 1, 2'd0);
    tick(); check_out();
    expect_out("tick3_toggle", 1, 0, 0, 2'd0);
    tick(); check_out();
    expect_out("timeout_4th_tick", 0, 0, 0, 2'd0);
    tick(); check_out();
    step(); step(); step();
    expect_out("no_retrigger_same_minute", 0, 0, 0, 2'd0);
    check_out();

    retrigger();
    expect_out("retrigger", 1, 0, 1, 2'd0);
    check_out();
    btn_snooze = 1'b1;
    expect_out("snooze_edge_captured_only", 1, 0, 1, 2'd0);
    step(); check_out();
    expect_out("snooze1_entry", 0, 1, 0, 2'd1);
    step(); check_out();
    step(); step();
    expect_out("held_snooze_level_inert", 0, 1, 0, 2'd1);
    check_out();
    btn_snooze = 1'b0;
    for (int i = 0; i < 59; i++) tick();
    expect_out("snooze1_before_expiry", 0, 1, 0, 2'd1);
    check_out();
    expect_out("snooze1_expiry", 1, 0, 1, 2'd1);
    tick(); check_out();

    expect_out("snooze2_entry", 0, 1, 0, 2'd2);
    press(1, 0); check_out();
    for (int i = 0; i < 60; i++) tick();
    expect_out("snooze2_expiry", 1, 0, 1, 2'd2);
    check_out();
    expect_out("snooze_limit_stops", 0, 0, 0, 2'd0);
    press(1, 0); check_out();

    retrigger();
    expect_out("ring_for_both_buttons", 1, 0, 1, 2'd0);
    check_out();
    expect_out("stop_wins_over_snooze", 0, 0, 0, 2'd0);
    press(1, 1); check_out();

    retrigger();
    expect_out("snooze_before_disarm", 0, 1, 0, 2'd1);
    press(1, 0); check_out();
    alarm_en = 1'b0;
    expect_out("disarm_in_snooze", 0, 0, 0, 2'd0);
    step(); check_out();
    retrigger();
    expect_out("match_while_disarmed", 0, 0, 0, 2'd0);
    check_out();
    alarm_en = 1'b1;
    step();
    expect_out("rearm_without_rise", 0, 0, 0, 2'd0);
    check_out();

    set_alarm(0, 8, 0, 0);
    step();
    sec_tick = 1'b1;
    set_alarm(0, 7, 3, 0);
    expect_out("alarm_edit_rings_entry_tick", 1, 0, 1, 2'd0);
    step(); check_out();
    sec_tick = 1'b0;
    tick(); tick(); tick();
    expect_out("entry_tick_not_counted", 1, 0, 0, 2'd0);
    check_out();
    expect_out("stop_button", 0, 0, 0, 2'd0);
    press(0, 1); check_out();

    retrigger();
    expect_out("ring_before_reset", 1, 0, 1, 2'd0);
    check_out();
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset_drop", 0, 0, 0, 2'd0);
    check_out();
    step();
    rst_n = 1'b1;
    expect_out("ring_after_reset_release", 1, 0, 1, 2'd0);
    step(); check_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
